// File: rtl/core_excp_commit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : core_excp_commit_pkg
// Purpose : Shared types for the exception/ERTN commit path: CSR field
//           layouts, the CSR snapshot bundle and the redirect request.
// Revision: 1.0 - initial release
// ============================================================================
package core_excp_commit_pkg;

  localparam int         ADDR_W     = 32;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef struct packed {
    logic [22:0] rsvd;
    logic [1:0]  datm;
    logic [1:0]  datf;
    logic        pg;
    logic        da;
    logic        ie;
    logic [1:0]  plv;
  } crmd_t;

  typedef struct packed {
    logic [28:0] rsvd;
    logic        pie;
    logic [1:0]  pplv;
  } prmd_t;

  typedef struct packed {
    logic        rsvd31;
    logic [8:0]  esubcode;
    logic [5:0]  ecode;
    logic [2:0]  rsvd15_13;
    logic [12:0] is;
  } estat_t;

  typedef struct packed {
    crmd_t       crmd;
    prmd_t       prmd;
    estat_t      estat;
    logic [31:0] era;
    logic [31:0] eentry;
    logic [31:0] tlbrentry;
  } csr_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] target;
  } redirect_req_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_REDIR = 1'b1
  } excp_state_e;

endpackage
`default_nettype wire

// File: rtl/core_excp_commit_if.sv
`default_nettype none
// ============================================================================
// Module  : core_excp_commit_if
// Purpose : Redirect handshake between the exception commit unit (master)
//           and the frontend PC-select (slave).
//   req   : valid + target PC, driven by the master
//   ready : frontend accepts the redirect, driven by the slave
// Revision: 1.0 - initial release
// ============================================================================
interface core_excp_commit_if;
  import core_excp_commit_pkg::*;

  redirect_req_t req;
  logic          ready;

  modport master (output req, input  ready);
  modport slave  (input  req, output ready);

endinterface
`default_nettype wire

// File: rtl/core_excp_commit.sv
`default_nettype none
// ============================================================================
// Module  : core_excp_commit
// Purpose : Consumes the commit-stage exception/ERTN event, produces the
//           architectural CSR side effects and redirects the frontend.
// Ports   :
//   clk, rst_n         clock, asynchronous active-low reset
//   valid_i .. pc_i    commit-slot event description
//   csr_i              current CSR snapshot
//   csr_we_o ..        one-cycle CSR update strobe, new values, field enables
//   redir              redirect handshake (master side)
//   stall_o            commit must hold while a redirect is pending
// Revision: 1.0 - initial release
// ============================================================================
module core_excp_commit
  import core_excp_commit_pkg::*;
#(
  parameter logic [5:0] ECODE_TLBR = core_excp_commit_pkg::ECODE_TLBR,
  parameter int         ADDR_W     = core_excp_commit_pkg::ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              valid_i,
  input  wire logic              excp_i,
  input  wire logic              ertn_inst_i,
  input  wire logic [5:0]        ecode_i,
  input  wire logic [8:0]        esubcode_i,
  input  wire logic              tlbr_i,
  input  wire logic              badv_valid_i,
  input  wire logic [ADDR_W-1:0] badv_i,
  input  wire logic [ADDR_W-1:0] pc_i,
  input  csr_t                   csr_i,
  output logic                   csr_we_o,
  output logic [31:0]            crmd_o,
  output logic [31:0]            prmd_o,
  output logic [ADDR_W-1:0]      era_o,
  output logic [ADDR_W-1:0]      badv_o,
  output logic                   era_we_o,
  output logic                   badv_we_o,
  output logic                   estat_we_o,
  output logic [5:0]             ecode_o,
  output logic [8:0]             esubcode_o,
  core_excp_commit_if.master     redir,
  output logic                   stall_o
);

  excp_state_e       r_state;
  excp_state_e       w_state_nxt;
  logic              w_event;
  crmd_t             w_crmd;
  prmd_t             w_prmd;
  logic [ADDR_W-1:0] w_target;

  crmd_t             r_crmd;
  prmd_t             r_prmd;
  logic [ADDR_W-1:0] r_era;
  logic [ADDR_W-1:0] r_badv;
  logic [ADDR_W-1:0] r_target;
  logic [5:0]        r_ecode;
  logic [8:0]        r_esubcode;
  logic              r_csr_we;
  logic              r_era_we;
  logic              r_badv_we;
  logic              r_estat_we;

  // State register; async reset drops the redirect immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Events are only recognised in IDLE; anything seen during REDIR is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_event     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i && (excp_i || ertn_inst_i)) begin
          w_event     = 1'b1;
          w_state_nxt = S_REDIR;
        end
      end
      S_REDIR: begin
        if (redir.ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next CRMD/PRMD and redirect target. excp_i takes priority over ERTN,
  // so the ERTN branch is simply the "not an exception" case.
  always_comb begin
    w_crmd   = csr_i.crmd;
    w_prmd   = csr_i.prmd;
    w_target = csr_i.eentry;
    if (excp_i) begin
      w_prmd.pplv = csr_i.crmd.plv;
      w_prmd.pie  = csr_i.crmd.ie;
      w_crmd.plv  = 2'd0;
      w_crmd.ie   = 1'b0;
      if (tlbr_i) begin
        w_crmd.da = 1'b1;
        w_crmd.pg = 1'b0;
        w_target  = csr_i.tlbrentry;
      end
    end else begin
      w_crmd.plv = csr_i.prmd.pplv;
      w_crmd.ie  = csr_i.prmd.pie;
      // Returning from a TLB refill handler re-enables paging.
      if (csr_i.estat.ecode == ECODE_TLBR) begin
        w_crmd.da = 1'b0;
        w_crmd.pg = 1'b1;
      end
      w_target = csr_i.era;
    end
  end

  // Enables are single-cycle strobes; data registers hold the last capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crmd     <= '0;
      r_prmd     <= '0;
      r_era      <= '0;
      r_badv     <= '0;
      r_target   <= '0;
      r_ecode    <= '0;
      r_esubcode <= '0;
      r_csr_we   <= 1'b0;
      r_era_we   <= 1'b0;
      r_badv_we  <= 1'b0;
      r_estat_we <= 1'b0;
    end else begin
      r_csr_we   <= w_event;
      r_era_we   <= w_event & excp_i;
      r_estat_we <= w_event & excp_i;
      r_badv_we  <= w_event & excp_i & badv_valid_i;
      if (w_event) begin
        r_crmd   <= w_crmd;
        r_prmd   <= w_prmd;
        r_target <= w_target;
        if (excp_i) begin
          r_era      <= pc_i;
          r_badv     <= badv_i;
          r_ecode    <= ecode_i;
          r_esubcode <= esubcode_i;
        end
      end
    end
  end

  assign csr_we_o   = r_csr_we;
  assign crmd_o     = r_crmd;
  assign prmd_o     = r_prmd;
  assign era_o      = r_era;
  assign badv_o     = r_badv;
  assign era_we_o   = r_era_we;
  assign badv_we_o  = r_badv_we;
  assign estat_we_o = r_estat_we;
  assign ecode_o    = r_ecode;
  assign esubcode_o = r_esubcode;
  assign stall_o    = (r_state == S_REDIR);
  assign redir.req  = '{valid: (r_state == S_REDIR), target: r_target};

endmodule
`default_nettype wire

// File: tb/tb_core_excp_commit.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_excp_commit
// Purpose : Self-checking bench for core_excp_commit: directed scenarios plus
//           randomized events compared against a word-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_core_excp_commit;
  import core_excp_commit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0, excp_i = 1'b0, ertn_inst_i = 1'b0;
  logic [5:0]  ecode_i = '0;
  logic [8:0]  esubcode_i = '0;
  logic        tlbr_i = 1'b0, badv_valid_i = 1'b0;
  logic [31:0] badv_i = '0, pc_i = '0;
  logic [31:0] crmd_w = '0, prmd_w = '0, estat_w = '0;
  logic [31:0] era_w = '0, eentry_w = '0, tlbre_w = '0;
  csr_t        csr_i;
  logic        csr_we_o, era_we_o, badv_we_o, estat_we_o, stall_o;
  logic [31:0] crmd_o, prmd_o, era_o, badv_o;
  logic [5:0]  ecode_o;
  logic [8:0]  esubcode_o;

  int n_total = 0;
  int n_pass  = 0;

  assign csr_i = {crmd_w, prmd_w, estat_w, era_w, eentry_w, tlbre_w};

  core_excp_commit_if u_if ();

  core_excp_commit u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .excp_i       (excp_i),
    .ertn_inst_i  (ertn_inst_i),
    .ecode_i      (ecode_i),
    .esubcode_i   (esubcode_i),
    .tlbr_i       (tlbr_i),
    .badv_valid_i (badv_valid_i),
    .badv_i       (badv_i),
    .pc_i         (pc_i),
    .csr_i        (csr_i),
    .csr_we_o     (csr_we_o),
    .crmd_o       (crmd_o),
    .prmd_o       (prmd_o),
    .era_o        (era_o),
    .badv_o       (badv_o),
    .era_we_o     (era_we_o),
    .badv_we_o    (badv_we_o),
    .estat_we_o   (estat_we_o),
    .ecode_o      (ecode_o),
    .esubcode_o   (esubcode_o),
    .redir        (u_if.master),
    .stall_o      (stall_o)
  );

  always #5 clk = ~clk;

  // Upstream must never present an event while commit is stalled.
  always @(negedge clk) begin
    if (rst_n && stall_o && valid_i && (excp_i || ertn_inst_i)) begin
      n_total++;
      $display("FAIL event_under_stall: event presented while stall_o=1");
    end
  end

  // Drive one event, check the CSR update, then hold ready low for
  // ready_delay REDIR cycles and check the handshake length and stability.
  task automatic run_event(input string nm, input bit excp, input bit ertn,
                           input bit tlbr, input bit bv, input logic [31:0] badv,
                           input logic [31:0] pc, input logic [5:0] ec,
                           input logic [8:0] esc, input int ready_delay);
    logic [31:0] e_crmd, e_prmd, e_target;
    int cnt, pulses;
    bit stall_bad, tgt_bad;
    // Reference model on whole 32-bit words: bits [2:0] of CRMD are {ie,plv}
    // and of PRMD are {pie,pplv}; bit 3 is DA, bit 4 is PG.
    if (excp) begin
      e_prmd   = (prmd_w & ~32'h7) | (crmd_w & 32'h7);
      e_crmd   = crmd_w & ~32'h7;
      if (tlbr) e_crmd = (e_crmd | 32'h8) & ~32'h10;
      e_target = tlbr ? tlbre_w : eentry_w;
    end else begin
      e_prmd   = prmd_w;
      e_crmd   = (crmd_w & ~32'h7) | (prmd_w & 32'h7);
      if (estat_w[21:16] == 6'h3F) e_crmd = (e_crmd & ~32'h8) | 32'h10;
      e_target = era_w;
    end

    @(negedge clk);
    valid_i = 1'b1; excp_i = excp; ertn_inst_i = ertn; tlbr_i = tlbr;
    badv_valid_i = bv; badv_i = badv; pc_i = pc; ecode_i = ec; esubcode_i = esc;
    u_if.ready = (ready_delay == 0);
    @(negedge clk);
    valid_i = 1'b0; excp_i = 1'b0; ertn_inst_i = 1'b0;

    n_total++;
    if (csr_we_o !== 1'b1) $display("FAIL %s csr_we: got %b want 1", nm, csr_we_o);
    else n_pass++;
    n_total++;
    if (crmd_o !== e_crmd) $display("FAIL %s crmd: got %h want %h", nm, crmd_o, e_crmd);
    else n_pass++;
    n_total++;
    if (prmd_o !== e_prmd) $display("FAIL %s prmd: got %h want %h", nm, prmd_o, e_prmd);
    else n_pass++;
    n_total++;
    if ({era_we_o, estat_we_o, badv_we_o} !== {excp, excp, excp & bv})
      $display("FAIL %s enables: got %b want %b", nm,
               {era_we_o, estat_we_o, badv_we_o}, {excp, excp, excp & bv});
    else n_pass++;
    if (excp) begin
      n_total++;
      if ({era_o, ecode_o, esubcode_o} !== {pc, ec, esc})
        $display("FAIL %s era/estat: got %h/%h/%h want %h/%h/%h", nm,
                 era_o, ecode_o, esubcode_o, pc, ec, esc);
      else n_pass++;
      if (bv) begin
        n_total++;
        if (badv_o !== badv) $display("FAIL %s badv: got %h want %h", nm, badv_o, badv);
        else n_pass++;
      end
    end
    n_total++;
    if (u_if.req.target !== e_target)
      $display("FAIL %s target: got %h want %h", nm, u_if.req.target, e_target);
    else n_pass++;

    cnt = 0; pulses = 1; stall_bad = 0; tgt_bad = 0;
    while (u_if.req.valid === 1'b1 && cnt < 40) begin
      cnt++;
      if (stall_o !== 1'b1) stall_bad = 1;
      if (u_if.req.target !== e_target) tgt_bad = 1;
      if (cnt > ready_delay) u_if.ready = 1'b1;
      @(negedge clk);
      if (csr_we_o === 1'b1) pulses++;
    end
    u_if.ready = 1'b0;
    n_total++;
    if (cnt != ready_delay + 1)
      $display("FAIL %s redirect_cycles: got %0d want %0d", nm, cnt, ready_delay + 1);
    else n_pass++;
    n_total++;
    if (stall_bad || tgt_bad || stall_o !== 1'b0)
      $display("FAIL %s stall/target_stable: got stall_bad=%0d tgt_bad=%0d stall_after=%b want 0/0/0",
               nm, stall_bad, tgt_bad, stall_o);
    else n_pass++;
    n_total++;
    if (pulses != 1) $display("FAIL %s csr_we_pulses: got %0d want 1", nm, pulses);
    else n_pass++;
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({csr_we_o, era_we_o, badv_we_o, estat_we_o, stall_o, u_if.req.valid} !== 6'b0 ||
        {crmd_o, prmd_o, era_o, badv_o, u_if.req.target} !== 160'b0 ||
        {ecode_o, esubcode_o} !== 15'b0)
      $display("FAIL reset_outputs: got nonzero outputs want all 0");
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    crmd_w = 32'h0000_0007; prmd_w = 32'h0; estat_w = 32'h0;
    eentry_w = 32'h1C00_8000; tlbre_w = 32'h1C00_F000; era_w = 32'h0;
    run_event("t1_excp", 1, 0, 0, 0, 32'h0, 32'h1C00_0100, 6'h0B, 9'h0, 0);
    run_event("t2_tlbr", 1, 0, 1, 1, 32'h0040_0000, 32'h1C00_0200, 6'h3F, 9'h0, 0);
    crmd_w = 32'h0000_0008; prmd_w = 32'h0000_0007; estat_w = {10'h0, 6'h3F, 16'h0};
    era_w = 32'h1C00_0204;
    run_event("t3_ertn", 0, 1, 0, 0, 32'h0, 32'h1C00_0300, 6'h0, 9'h0, 0);
    crmd_w = 32'h0000_0013;
    run_event("t4_stall", 1, 0, 0, 0, 32'h0, 32'h1C00_0400, 6'h08, 9'h1, 4);
    run_event("t5_both", 1, 1, 0, 0, 32'h0, 32'h1C00_0500, 6'h09, 9'h0, 0);
  endtask

  task automatic test_reset_mid_redir();
    @(negedge clk);
    valid_i = 1'b1; excp_i = 1'b1; ertn_inst_i = 1'b0; tlbr_i = 1'b0;
    u_if.ready = 1'b0;
    @(negedge clk);
    valid_i = 1'b0; excp_i = 1'b0;
    n_total++;
    if (u_if.req.valid !== 1'b1) $display("FAIL rst_mid pre_valid: got %b want 1", u_if.req.valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({u_if.req.valid, stall_o} !== 2'b00)
      $display("FAIL rst_mid async_drop: got valid/stall=%b want 00", {u_if.req.valid, stall_o});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if ({u_if.req.valid, stall_o, csr_we_o} !== 3'b000)
      $display("FAIL rst_mid idle_after: got %b want 000", {u_if.req.valid, stall_o, csr_we_o});
    else n_pass++;
    run_event("rst_mid_next", 1, 0, 0, 1, 32'hDEAD_0000, 32'h1C00_0600, 6'h01, 9'h2, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      bit ex, er, tl, bv;
      int k;
      k  = $urandom_range(0, 2);
      ex = (k != 1);
      er = (k != 0);
      tl = ex & $urandom_range(0, 1);
      bv = $urandom_range(0, 1);
      crmd_w = $urandom; prmd_w = $urandom; era_w = $urandom;
      eentry_w = $urandom; tlbre_w = $urandom;
      estat_w = $urandom;
      if ($urandom_range(0, 1)) estat_w[21:16] = 6'h3F;
      run_event($sformatf("rand%0d", i), ex, er, tl, bv, $urandom, $urandom,
                6'($urandom), 9'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    u_if.ready = 1'b0;
    test_reset();
    test_directed();
    test_reset_mid_redir();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
